// File: rtl/switch_read_arbiter.sv
`timescale 1ns/1ps
// Two-requester read arbiter for the switch input peripheral: one read in flight,
// registered handshake outputs and saturating grant counters. Define
// SWARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module switch_read_arbiter #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              switclk,
   input  logic              switrst,
   input  logic [1:0]        req,
   input  logic [1:0]        req_addr0,
   input  logic [1:0]        req_addr1,
   output logic [1:0]        ack,
   output logic [1:0]        err,
   output logic [DATA_W-1:0] rdata,
   output logic              switchcs,
   output logic              switchread,
   output logic [1:0]        switchaddr,
   input  logic [DATA_W-1:0] switchrdata,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t     state;
   logic       winner;
   logic       pick;
   logic [1:0] pick_addr;
   logic       pick_legal;
   logic       grant_now;

`ifndef SWARB_FIXED_PRIO_EN
   logic       last_grant;
`endif

   function automatic logic [1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      pick = 1'b0;
      if (req == 2'b10) begin
         pick = 1'b1;
      end else if (req == 2'b11) begin
`ifdef SWARB_FIXED_PRIO_EN
         pick = 1'b0;
`else
         pick = ~last_grant;
`endif
      end
   end

   assign pick_addr  = pick ? req_addr1 : req_addr0;
   assign pick_legal = ~pick_addr[0];
   assign grant_now  = (state == IDLE) && (|req);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge switclk or negedge switrst) begin
      if (!switrst) begin
         state      <= IDLE;
         winner     <= 1'b0;
         ack        <= 2'b00;
         err        <= 2'b00;
         rdata      <= '0;
         switchcs   <= 1'b0;
         switchread <= 1'b0;
         switchaddr <= 2'b00;
`ifndef SWARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  winner <= pick;
`ifndef SWARB_FIXED_PRIO_EN
                  last_grant <= pick;
`endif
                  if (pick_legal) begin
                     switchcs   <= 1'b1;
                     switchread <= 1'b1;
                     switchaddr <= pick_addr;
                     state      <= ISSUE;
                  end else begin
                     // Odd bank numbers do not exist; answer at once without a bus cycle.
                     rdata <= '0;
                     ack   <= onehot(pick);
                     err   <= onehot(pick);
                     state <= RESP;
                  end
               end
            end
            ISSUE: begin
               rdata      <= switchrdata;
               ack        <= onehot(winner);
               switchcs   <= 1'b0;
               switchread <= 1'b0;
               state      <= RESP;
            end
            RESP: begin
               ack   <= 2'b00;
               err   <= 2'b00;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Clear wins over a same-cycle grant; counters stick at their maximum.
   always_ff @(posedge switclk or negedge switrst) begin
      if (!switrst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (clr_cnt) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (grant_now) begin
         if (!pick && grant_cnt0 != CNT_MAX) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         if (pick && grant_cnt1 != CNT_MAX)  grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_switch_read_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for switch_read_arbiter: stimulus queues expected responses,
// a negedge monitor pops one per ack pulse and checks data, flags and cycle.
module tb_switch_read_arbiter;

   typedef struct {
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [15:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        switrst = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [1:0]  req_addr0 = 2'b00;
   logic [1:0]  req_addr1 = 2'b00;
   logic [1:0]  ack;
   logic [1:0]  err;
   logic [15:0] rdata;
   logic        switchcs;
   logic        switchread;
   logic [1:0]  switchaddr;
   logic [15:0] switchrdata = 16'h0000;
   logic        clr_cnt = 1'b0;
   logic [7:0]  grant_cnt0;
   logic [7:0]  grant_cnt1;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   resp_count = 0;
   int   exp_total = 0;
   int   c0;
   exp_t sb[$];

   switch_read_arbiter #(.DATA_W(16), .CNT_W(8)) dut (
      .switclk    (clk),
      .switrst    (switrst),
      .req        (req),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .ack        (ack),
      .err        (err),
      .rdata      (rdata),
      .switchcs   (switchcs),
      .switchread (switchread),
      .switchaddr (switchaddr),
      .switchrdata(switchrdata),
      .clr_cnt    (clr_cnt),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [1:0] a, input logic [1:0] e, input logic [15:0] d,
                       input int c);
      exp_t x;
      x.ack = a; x.err = e; x.rdata = d; x.cyc = c;
      sb.push_back(x);
      exp_total++;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input int max_cyc);
      int k = 0;
      while (resp_count < exp_total && k < max_cyc) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("resp_wait", resp_count, exp_total);
   endtask

   // Monitor: every cycle with an ack pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      if (switrst && ack != 2'b00) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", {30'd0, ack}, 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            check("ack", {30'd0, ack}, {30'd0, x.ack});
            check("err", {30'd0, err}, {30'd0, x.err});
            check("rdata", {16'd0, rdata}, {16'd0, x.rdata});
            check("ack_cycle", cyc, x.cyc);
         end
         resp_count++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      switrst = 1'b0;
      req = 2'b00;
      clr_cnt = 1'b0;
      repeat (2) step();
      switrst = 1'b1;
   endtask

   initial begin
      // Reset values
      repeat (2) step();
      check("rst_ack", {30'd0, ack}, 32'd0);
      check("rst_err", {30'd0, err}, 32'd0);
      check("rst_cs", {31'd0, switchcs}, 32'd0);
      check("rst_read", {31'd0, switchread}, 32'd0);
      check("rst_addr", {30'd0, switchaddr}, 32'd0);
      check("rst_rdata", {16'd0, rdata}, 32'd0);
      check("rst_cnt0", {24'd0, grant_cnt0}, 32'd0);
      check("rst_cnt1", {24'd0, grant_cnt1}, 32'd0);
      switrst = 1'b1;
      step();

      // Single legal read from requester 0
      switchrdata = 16'hA5C3;
      req_addr0 = 2'b00;
      req = 2'b01;
      c0 = cyc;
      push(2'b01, 2'b00, 16'hA5C3, c0 + 2);
      step();
      check("t1_cs", {31'd0, switchcs}, 32'd1);
      check("t1_read", {31'd0, switchread}, 32'd1);
      check("t1_addr", {30'd0, switchaddr}, 32'd0);
      wait_resp(20);
      req = 2'b00;
      check("t1_cnt0", {24'd0, grant_cnt0}, 32'd1);

      // Both requesting, held through four grants, from fresh reset
      do_reset();
      step();
      switchrdata = 16'h1234;
      req_addr0 = 2'b00;
      req_addr1 = 2'b10;
      req = 2'b11;
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
`ifdef SWARB_FIXED_PRIO_EN
         push(2'b01, 2'b00, 16'h1234, c0 + 2 + 3 * k);
`else
         push((k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 16'h1234, c0 + 2 + 3 * k);
`endif
      end
      wait_resp(40);
      req = 2'b00;
`ifdef SWARB_FIXED_PRIO_EN
      check("t2_cnt0", {24'd0, grant_cnt0}, 32'd4);
      check("t2_cnt1", {24'd0, grant_cnt1}, 32'd0);
`else
      check("t2_cnt0", {24'd0, grant_cnt0}, 32'd2);
      check("t2_cnt1", {24'd0, grant_cnt1}, 32'd2);
`endif
      repeat (2) step();

      // Illegal bank from requester 1: immediate error response, bus untouched
      req_addr1 = 2'b01;
      req = 2'b10;
      c0 = cyc;
      push(2'b10, 2'b10, 16'h0000, c0 + 1);
      step();
      check("t3_cs", {31'd0, switchcs}, 32'd0);
      check("t3_read", {31'd0, switchread}, 32'd0);
      wait_resp(20);
      req = 2'b00;
      repeat (2) step();

      // Legal bank 2 from requester 1
      req_addr1 = 2'b10;
      switchrdata = {8'h00, 8'h3C};
      req = 2'b10;
      c0 = cyc;
      push(2'b10, 2'b00, 16'h003C, c0 + 2);
      step();
      check("t4_cs", {31'd0, switchcs}, 32'd1);
      check("t4_addr", {30'd0, switchaddr}, 32'd2);
      wait_resp(20);
      req = 2'b00;
      repeat (2) step();

      // Reset while the read is in flight
      req_addr0 = 2'b00;
      req = 2'b01;
      step();
      check("t5_cs_issue", {31'd0, switchcs}, 32'd1);
      @(negedge clk);
      switrst = 1'b0;
      #1;
      check("t5_cs", {31'd0, switchcs}, 32'd0);
      check("t5_read", {31'd0, switchread}, 32'd0);
      check("t5_ack", {30'd0, ack}, 32'd0);
      check("t5_cnt0", {24'd0, grant_cnt0}, 32'd0);
      check("t5_cnt1", {24'd0, grant_cnt1}, 32'd0);
      req = 2'b00;
      repeat (2) step();
      switrst = 1'b1;
      repeat (4) step();
      check("t5_idle_ack", {30'd0, ack}, 32'd0);
      check("t5_rdata", {16'd0, rdata}, 32'd0);

      // Counter saturation: 300 fast error grants to requester 0
      req_addr0 = 2'b01;
      req = 2'b01;
      c0 = cyc;
      for (int k = 0; k < 300; k++) push(2'b01, 2'b01, 16'h0000, c0 + 1 + 2 * k);
      wait_resp(700);
      req = 2'b00;
      check("t6_sat", {24'd0, grant_cnt0}, 32'd255);
      repeat (3) step();
      check("t6_hold", {24'd0, grant_cnt0}, 32'd255);

      // Clear in the same cycle as a new grant
      req = 2'b01;
      clr_cnt = 1'b1;
      c0 = cyc;
      push(2'b01, 2'b01, 16'h0000, c0 + 1);
      step();
      clr_cnt = 1'b0;
      check("t7_clr", {24'd0, grant_cnt0}, 32'd0);
      wait_resp(20);
      req = 2'b00;
      repeat (3) step();
      check("t7_after", {24'd0, grant_cnt0}, 32'd0);

      check("sb_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
